// File: rtl/counter_agent_pkg.sv
// Shared types and constants for the counter stimulus agent (counter_stim_agent).
package counter_agent_pkg;

    typedef enum logic [1:0] {
        MODE_LFSR = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_ALT  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DUT_RST,
        S_RUN,
        S_DRAIN
    } state_e;

    localparam int DUT_RST_CYCLES = 2;
    localparam int ALT_PERIOD     = 16;
    localparam int LFSR_W         = 16;

    // x^16+x^14+x^13+x^11+1 in right-shifting form: bits 0,2,3,5 feed bit 15.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    // A per-channel seed of zero would lock the LFSR, so fall back to the base seed.
    function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [LFSR_W-1:0] base, input int idx);
        logic [LFSR_W-1:0] s;
        s = base ^ LFSR_W'(idx);
        return (s == '0) ? base : s;
    endfunction

endpackage

// File: rtl/counter_agent_lfsr.sv
// One 16-bit Fibonacci LFSR with synchronous seed load and step enable.
module counter_agent_lfsr
    import counter_agent_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] value
);

    logic feedback;

    assign feedback = ^(value & LFSR_TAPS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= seed;
        end else if (step) begin
            value <= {feedback, value[LFSR_W-1:1]};
        end
    end

endmodule

// File: rtl/counter_stim_agent.sv
// Stimulus agent driving NCH up/down counters; reference models and error
// outputs exist only when COUNTER_AGENT_CHECK_EN is defined.
module counter_stim_agent
    import counter_agent_pkg::*;
#(
    parameter int          N          = 8,
    parameter int          NCH        = 2,
    parameter int          NUM_CYCLES = 200,
    parameter logic [15:0] SEED       = 16'hACE1,
    localparam int         CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic [NCH-1:0]   dut_rst_n,
    output logic [NCH-1:0]   en,
    output logic [NCH-1:0]   up_dn,
    input  logic [NCH*N-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err_valid,
    output logic [CHW-1:0]   err_ch,
    output logic [15:0]      err_cnt,
    output state_e           state_dbg
);

    // Handshake: start is accepted only while busy is low (IDLE); a start seen
    // while busy is dropped. done pulses once when the run completes.

    localparam int PCW = $clog2(NUM_CYCLES + 1);

    state_e             state;
    mode_e              mode_q;
    logic [PCW-1:0]     phase_cnt;
    logic [LFSR_W-1:0]  lfsr_val [NCH];
    logic [NCH-1:0]     next_en;
    logic [NCH-1:0]     next_up;
    logic [31:0]        next_idx;
    logic               alt_up;
    logic               rst_last;
    logic               run_last;
    logic               lfsr_load;
    logic               lfsr_step;

    assign state_dbg = state;
    assign rst_last  = (state == S_DUT_RST) && (phase_cnt == PCW'(DUT_RST_CYCLES - 1));
    assign run_last  = (state == S_RUN) && (phase_cnt == PCW'(NUM_CYCLES - 1));
    assign lfsr_load = (state == S_IDLE) && start;
    assign lfsr_step = rst_last || ((state == S_RUN) && !run_last);

    for (genvar i = 0; i < NCH; i++) begin : g_lfsr
        counter_agent_lfsr u_lfsr (
            .clk   (clk),
            .rst   (rst),
            .load  (lfsr_load),
            .step  (lfsr_step),
            .seed  (lfsr_seed(SEED, i)),
            .value (lfsr_val[i])
        );
    end

    // Stimulus for the RUN cycle that begins at the coming edge.
    always_comb begin
        next_idx = (state == S_RUN) ? (32'(phase_cnt) + 32'd1) : 32'd0;
        alt_up   = (next_idx % (2 * ALT_PERIOD)) < ALT_PERIOD;
        next_en  = '0;
        next_up  = '0;
        for (int i = 0; i < NCH; i++) begin
            case (mode_q)
                MODE_LFSR: begin next_en[i] = lfsr_val[i][0]; next_up[i] = lfsr_val[i][1]; end
                MODE_UP:   begin next_en[i] = 1'b1; next_up[i] = 1'b1; end
                MODE_DOWN: begin next_en[i] = 1'b1; next_up[i] = 1'b0; end
                default:   begin next_en[i] = 1'b1; next_up[i] = alt_up; end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mode_q    <= MODE_LFSR;
            phase_cnt <= '0;
            dut_rst_n <= '0;
            en        <= '0;
            up_dn     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q    <= mode_e'(mode);
                        phase_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= S_DUT_RST;
                    end
                end
                S_DUT_RST: begin
                    if (rst_last) begin
                        state     <= S_RUN;
                        phase_cnt <= '0;
                        dut_rst_n <= '1;
                        en        <= next_en;
                        up_dn     <= next_up;
                    end else begin
                        phase_cnt <= phase_cnt + PCW'(1);
                    end
                end
                S_RUN: begin
                    if (run_last) begin
                        state <= S_DRAIN;
                        en    <= '0;
                        up_dn <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + PCW'(1);
                        en        <= next_en;
                        up_dn     <= next_up;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    dut_rst_n <= '0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end
            endcase
        end
    end

`ifdef COUNTER_AGENT_CHECK_EN
    logic [N-1:0]   model [NCH];
    logic [NCH-1:0] mism;
    logic [15:0]    mism_cnt;
    logic [CHW-1:0] first_ch;
    logic           compare_now;
    logic [16:0]    err_sum;

    // The counter reflects the previous edge's stimulus, so compare one cycle late.
    always_comb begin
        compare_now = ((state == S_RUN) && (phase_cnt != '0)) || (state == S_DRAIN);
        mism        = '0;
        mism_cnt    = '0;
        first_ch    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            mism[i]  = compare_now && (count[i*N +: N] != model[i]);
            mism_cnt = mism_cnt + 16'(mism[i]);
            if (mism[i]) first_ch = CHW'(i);
        end
        err_sum = {1'b0, err_cnt} + {1'b0, mism_cnt};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) model[i] <= '0;
            err_valid <= 1'b0;
            err_ch    <= '0;
            err_cnt   <= '0;
        end else if (lfsr_load) begin
            for (int i = 0; i < NCH; i++) model[i] <= '0;
            err_valid <= 1'b0;
            err_ch    <= '0;
            err_cnt   <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (en[i]) model[i] <= up_dn[i] ? (model[i] + N'(1)) : (model[i] - N'(1));
            end
            if (|mism) begin
                err_valid <= 1'b1;
                if (!err_valid) err_ch <= first_ch;
                err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            end
        end
    end
`else
    logic unused_count;

    assign unused_count = ^count;
    assign err_valid    = 1'b0;
    assign err_ch       = '0;
    assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_counter_stim_agent.sv
// Self-checking bench for counter_stim_agent: ideal counters plus stuck-at faults.
`timescale 1ns/1ps
module tb_counter_stim_agent;
    import counter_agent_pkg::*;

    localparam int          N    = 8;
    localparam int          NCH  = 2;
    localparam int          NC   = 200;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int          W    = 2 * NCH;
`ifdef COUNTER_AGENT_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       mode  = 2'b00;
    logic [NCH-1:0]   dut_rst_n, en, up_dn;
    logic [NCH*N-1:0] count;
    logic             busy, done, err_valid;
    logic [CHW-1:0]   err_ch;
    logic [15:0]      err_cnt;
    state_e           state_dbg;

    logic [N-1:0]     cnt_q [NCH];
    logic [NCH-1:0]   stuck = '0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   trace_q[$];
    logic [W-1:0]   trace_a[$];
    int             exp_err_cnt;
    logic           exp_err_valid;
    logic [CHW-1:0] exp_err_ch;
    logic [N-1:0]   exp_final [NCH];
    logic [N-1:0]   obs_final [NCH];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached, required run to finish");
        $fatal(1, "watchdog");
    end

    counter_stim_agent #(.N(N), .NCH(NCH), .NUM_CYCLES(NC), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .dut_rst_n(dut_rst_n), .en(en), .up_dn(up_dn), .count(count),
        .busy(busy), .done(done), .err_valid(err_valid), .err_ch(err_ch),
        .err_cnt(err_cnt), .state_dbg(state_dbg)
    );

    // Ideal 1-cycle counters under test; stuck channels read back as zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (!dut_rst_n[i])  cnt_q[i] <= '0;
            else if (en[i])     cnt_q[i] <= up_dn[i] ? (cnt_q[i] + N'(1)) : (cnt_q[i] - N'(1));
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NCH; i++) count[i*N +: N] = stuck[i] ? '0 : cnt_q[i];
    end

    // ---------------- reference model ----------------
    task automatic build_ref(input logic [1:0] m, input logic [NCH-1:0] sm);
        logic [15:0]    s [NCH];
        logic [N-1:0]   v [NCH];
        logic [NCH-1:0] e_v, u_v;
        logic           fb;
        exp_q.delete();
        exp_err_cnt   = 0;
        exp_err_valid = 1'b0;
        exp_err_ch    = '0;
        for (int i = 0; i < NCH; i++) begin
            s[i] = SEED ^ 16'(i);
            if (s[i] == 16'h0000) s[i] = SEED;
            v[i] = '0;
        end
        for (int k = 0; k < NC; k++) begin
            for (int i = 0; i < NCH; i++) begin
                case (m)
                    2'b00:   begin e_v[i] = s[i][0]; u_v[i] = s[i][1]; end
                    2'b01:   begin e_v[i] = 1'b1;    u_v[i] = 1'b1;    end
                    2'b10:   begin e_v[i] = 1'b1;    u_v[i] = 1'b0;    end
                    default: begin e_v[i] = 1'b1;    u_v[i] = ((k / 16) % 2) == 0; end
                endcase
            end
            exp_q.push_back({u_v, e_v});
            for (int i = 0; i < NCH; i++) begin
                fb   = s[i][0] ^ s[i][2] ^ s[i][3] ^ s[i][5];
                s[i] = {fb, s[i][15:1]};
                if (e_v[i]) v[i] = u_v[i] ? (v[i] + N'(1)) : (v[i] - N'(1));
                if (CHECK_EN && sm[i] && (v[i] != '0)) begin
                    if (!exp_err_valid) exp_err_ch = CHW'(i);
                    exp_err_valid = 1'b1;
                    exp_err_cnt++;
                end
            end
        end
        for (int i = 0; i < NCH; i++) exp_final[i] = v[i];
    endtask

    // ---------------- driver: one full run ----------------
    task automatic run_once(input logic [1:0] m, input logic [NCH-1:0] sm, input bit poke, input string tag);
        int cyc, done_cyc, busy_bad, proto_bad, trace_bad;
        logic [W-1:0] o, e;
        build_ref(m, sm);
        trace_q.delete();
        @(negedge clk);
        stuck = sm; mode = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; done_cyc = 0; busy_bad = 0; proto_bad = 0; trace_bad = 0;
        while (done_cyc == 0 && cyc <= NC + 40) begin
            if (done) begin
                done_cyc = cyc;
                for (int i = 0; i < NCH; i++) obs_final[i] = cnt_q[i];
            end else begin
                if (!busy) busy_bad++;
                if (cyc >= 3 && cyc <= NC + 2) begin
                    o = {up_dn, en};
                    trace_q.push_back(o);
                    if (dut_rst_n !== '1) proto_bad++;
                    if (exp_q.size() == 0) trace_bad++;
                    else begin
                        e = exp_q.pop_front();
                        if (o !== e) trace_bad++;
                    end
                end else if (cyc < 3 && dut_rst_n !== '0) proto_bad++;
                start = poke && (cyc == 60 || cyc == NC + 3);
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        n_cmp++; if (done_cyc != NC + 4) begin n_bad++; $display("FAIL %s done_cycle: got %0d required %0d", tag, done_cyc, NC + 4); end
        n_cmp++; if (busy_bad != 0 || busy !== 1'b0) begin n_bad++; $display("FAIL %s busy: low cycles %0d, at done %b; required 0, 0", tag, busy_bad, busy); end
        n_cmp++; if (trace_bad + exp_q.size() != 0) begin n_bad++; $display("FAIL %s stimulus_trace: bad %0d left %0d required 0", tag, trace_bad, exp_q.size()); end
        n_cmp++; if (proto_bad != 0) begin n_bad++; $display("FAIL %s dut_rst_n: bad cycles %0d required 0", tag, proto_bad); end
        for (int i = 0; i < NCH; i++) begin
            n_cmp++; if (obs_final[i] !== exp_final[i]) begin n_bad++; $display("FAIL %s final_count[%0d]: got %h required %h", tag, i, obs_final[i], exp_final[i]); end
        end
        n_cmp++; if (err_valid !== exp_err_valid) begin n_bad++; $display("FAIL %s err_valid: got %b required %b", tag, err_valid, exp_err_valid); end
        n_cmp++; if (err_ch !== exp_err_ch) begin n_bad++; $display("FAIL %s err_ch: got %0d required %0d", tag, err_ch, exp_err_ch); end
        n_cmp++; if (err_cnt !== 16'(exp_err_cnt)) begin n_bad++; $display("FAIL %s err_cnt: got %0d required %0d", tag, err_cnt, exp_err_cnt); end
        @(negedge clk);
        n_cmp++; if ({done, en, dut_rst_n} !== '0) begin n_bad++; $display("FAIL %s after_done: done/en/dut_rst_n %b required 0", tag, {done, en, dut_rst_n}); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (dut_rst_n !== '0)   begin n_bad++; $display("FAIL reset dut_rst_n: got %b required 0", dut_rst_n); end
        n_cmp++; if (en !== '0 || up_dn !== '0) begin n_bad++; $display("FAIL reset en_up_dn: got %b %b required 0 0", en, up_dn); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset busy_done: got %b %b required 0 0", busy, done); end
        n_cmp++; if (err_valid !== 1'b0 || err_ch !== '0 || err_cnt !== '0) begin n_bad++; $display("FAIL reset err: got %b %0d %0d required 0 0 0", err_valid, err_ch, err_cnt); end
        n_cmp++; if (state_dbg !== S_IDLE) begin n_bad++; $display("FAIL reset state: got %0d required %0d", state_dbg, S_IDLE); end
    endtask

    task automatic test_modes();
        run_once(2'b01, '0, 1'b0, "mode_up");
        n_cmp++; if (obs_final[0] !== 8'hC8 || obs_final[1] !== 8'hC8) begin n_bad++; $display("FAIL mode_up const: got %h %h required c8", obs_final[0], obs_final[1]); end
        run_once(2'b10, '0, 1'b0, "mode_down");
        n_cmp++; if (obs_final[0] !== 8'h38 || obs_final[1] !== 8'h38) begin n_bad++; $display("FAIL mode_down const: got %h %h required 38", obs_final[0], obs_final[1]); end
        run_once(2'b11, '0, 1'b0, "mode_alt");
        n_cmp++; if (obs_final[0] !== 8'h08 || obs_final[1] !== 8'h08) begin n_bad++; $display("FAIL mode_alt const: got %h %h required 08", obs_final[0], obs_final[1]); end
    endtask

    task automatic test_stuck();
        run_once(2'b01, 2'b10, 1'b0, "stuck_ch1");
        n_cmp++; if (err_cnt !== (CHECK_EN ? 16'd200 : 16'd0) || err_ch !== CHW'(CHECK_EN ? 1 : 0)) begin n_bad++; $display("FAIL stuck_ch1 const: got cnt %0d ch %0d", err_cnt, err_ch); end
        run_once(2'b01, 2'b11, 1'b0, "stuck_both");
        n_cmp++; if (err_cnt !== (CHECK_EN ? 16'd400 : 16'd0) || err_ch !== '0) begin n_bad++; $display("FAIL stuck_both const: got cnt %0d ch %0d", err_cnt, err_ch); end
    endtask

    task automatic test_lfsr();
        int diff, rep_bad;
        run_once(2'b00, '0, 1'b0, "lfsr_a");
        trace_a = trace_q;
        diff = 0;
        foreach (trace_a[k]) if (trace_a[k][0] != trace_a[k][1] || trace_a[k][2] != trace_a[k][3]) diff++;
        n_cmp++; if (diff == 0) begin n_bad++; $display("FAIL lfsr channel_diff: got %0d differing cycles required >0", diff); end
        run_once(2'b00, '0, 1'b0, "lfsr_b");
        rep_bad = (trace_q.size() == trace_a.size()) ? 0 : 1;
        foreach (trace_q[k]) if (k < trace_a.size() && trace_q[k] !== trace_a[k]) rep_bad++;
        n_cmp++; if (rep_bad != 0) begin n_bad++; $display("FAIL lfsr repeat: got %0d differences required 0", rep_bad); end
    endtask

    task automatic test_abort();
        int done_seen;
        @(negedge clk);
        stuck = 2'b10; mode = 2'b01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (52) @(negedge clk);
        n_cmp++; if (err_cnt !== (CHECK_EN ? 16'd49 : 16'd0)) begin n_bad++; $display("FAIL abort pre_rst err_cnt: got %0d required %0d", err_cnt, CHECK_EN ? 49 : 0); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({dut_rst_n, en, up_dn, busy, done} !== '0 || state_dbg !== S_IDLE) begin n_bad++; $display("FAIL abort outputs: got %b state %0d required 0", {dut_rst_n, en, up_dn, busy, done}, state_dbg); end
        n_cmp++; if (err_valid !== 1'b0 || err_cnt !== '0 || err_ch !== '0) begin n_bad++; $display("FAIL abort err: got %b %0d %0d required 0", err_valid, err_cnt, err_ch); end
        rst = 1'b0;
        done_seen = 0;
        repeat (NC + 10) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        n_cmp++; if (done_seen != 0) begin n_bad++; $display("FAIL abort no_done: got %0d pulses required 0", done_seen); end
        run_once(2'b01, '0, 1'b0, "after_abort");
    endtask

    task automatic test_back_to_back();
        run_once(2'b01, 2'b01, 1'b1, "start_ignored");
        run_once(2'b10, '0, 1'b0, "back_to_back");
    endtask

    task automatic test_random();
        logic [1:0]     m;
        logic [NCH-1:0] sm;
        for (int r = 0; r < 4; r++) begin
            m  = 2'($urandom_range(0, 3));
            sm = NCH'($urandom_range(0, (1 << NCH) - 1));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_once(m, sm, 1'($urandom_range(0, 1)), $sformatf("random%0d_m%0d_s%0d", r, m, sm));
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_stuck();
        test_lfsr();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_stim_agent.md
# counter_stim_agent

Parametrised, self-checking stimulus agent for NCH independent up/down counters of width N. On a start pulse it resets the counters, drives en/up_dn per a selectable pattern for a fixed run length, and tracks every channel against an internal reference model. It reports completion and mismatch statistics. It sits in the counter test harness and drives the DUT directly; no separate driver or monitor is needed.

## Interface
- N, 8: counter width.
- NCH, 2: number of counter channels (≥1).
- NUM_CYCLES, 200: RUN-phase length in cycles (≥2).
- SEED, 16'hACE1: base LFSR seed.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; ignored unless idle.
- mode  in  2  00 LFSR random, 01 count up, 10 count down, 11 alternate; sampled with start.
- dut_rst_n  out  NCH  active-low reset to each counter.
- en  out  NCH  per-channel enable.
- up_dn  out  NCH  per-channel direction (1 = up).
- count  in  NCH*N  channel i at [i*N +: N].
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at end of run.
- err_valid  out  1  sticky: at least one mismatch this run.
- err_ch  out  max(1,$clog2(NCH))  channel of first mismatch.
- err_cnt  out  16  total mismatches, saturating at 16'hFFFF.

## Operation
- FSM states: IDLE → DUT_RST → RUN → DRAIN → IDLE.
- IDLE: dut_rst_n all 0, en/up_dn 0. start=1 latches mode, clears err_valid/err_ch/err_cnt and models, seeds LFSRs, goes to DUT_RST.
- DUT_RST: 2 cycles, dut_rst_n all 0. Then RUN.
- RUN: NUM_CYCLES cycles. dut_rst_n all 1. en/up_dn are registered and per channel:
  - 00: 16-bit Fibonacci LFSR per channel (x^16+x^14+x^13+x^11+1), seed SEED^i (SEED if result 0); en=bit0, up_dn=bit1; shift each RUN cycle.
  - 01: en=1, up_dn=1. 10: en=1, up_dn=0.
  - 11: en=1; up_dn=1 for RUN cycles 0–15, 0 for 16–31, repeating.
- Model: per channel, N-bit. On each edge where driven en=1, add 1 if up_dn, else subtract 1, modulo 2^N (wraps FF↔00).
- Compare: in the cycle after each RUN cycle (RUN cycles 2..NUM_CYCLES and DRAIN), count[i] vs model[i], all channels in parallel: NUM_CYCLES compares per channel.
- Mismatch: err_cnt += number of mismatching channels that cycle (saturating). First mismatch sets err_valid and err_ch; on a tie, the lowest index wins.
- DRAIN: 1 cycle, final compare, en 0. Then IDLE with done=1 for one cycle; busy falls the same cycle.
- Results hold until the next accepted start.

## Timing
- Reset values: dut_rst_n 0, en 0, up_dn 0, busy 0, done 0, err_valid 0, err_ch 0, err_cnt 0, state IDLE.
- start is sampled at edge 0. DUT_RST occupies cycles 1–2, RUN 3..NUM_CYCLES+2, DRAIN NUM_CYCLES+3. done pulses in cycle NUM_CYCLES+4.
- The DUT is required to update count on the same edge that samples en/up_dn (1-cycle counter).
- rst mid-run: immediate abort to reset values. No done pulse; results are lost.
- start while busy: ignored, no side effect.

## Configuration
- COUNTER_AGENT_CHECK_EN defined: reference models, comparators and error outputs are present as above.
- Not defined: no models or comparators; err_valid, err_ch and err_cnt are tied to 0. Stimulus, FSM, busy and done are unchanged.

## Structure
- Package counter_agent_pkg holds:
  - mode_e enum: MODE_LFSR, MODE_UP, MODE_DOWN, MODE_ALT.
  - state_e enum.
  - DUT_RST_CYCLES=2, ALT_PERIOD=16.
  - LFSR_W=16 and the tap mask.
- Sub-module counter_agent_lfsr: one 16-bit LFSR with seed load and step enable, instantiated NCH times in a generate loop.

## Test plan
- Mode 01, two ideal counters, N=8, NUM_CYCLES=200 → both counts end at 8'hC8; err_valid 0, err_cnt 0; done in cycle 204 after start.
- Mode 10, ideal counters → both end at 8'h38 (0−200 mod 256); err_cnt 0. Mode 11 → ends at 8'h08, with wrap past 00 exercised.
- Mode 01, channel 1 count stuck at 0 → err_valid 1, err_ch 1, err_cnt 200. Both channels stuck → err_ch 0, err_cnt 400.
- Mode 00, ideal counters → err_cnt 0; en/up_dn differ between channels; a repeat run reproduces identical traces.
- rst asserted in RUN cycle 50 → all outputs at reset values next cycle, no done. A new start gives a full clean run.
- start pulsed during RUN and DRAIN → ignored, single done. Without COUNTER_AGENT_CHECK_EN, the stuck-at test gives err_cnt 0.
